irq_dispatch_seq: RTL and testbench

Interrupt dispatch sequencer for the SM83 core. Owns the master interrupt enable (IME) and its EI delay, parks the core in HALT, and runs the 5-M-cycle service sequence: two internal waits, push PC high, push PC low, load vector. Sits between the IE/IF latch array and the core's decoder and bus unit. It takes the qualified pending vector (IE & IF) and returns the one-hot flag clear plus the vector address.

---
 rtl/irq_dispatch_seq.sv | 189 ++++++++++++++++++
 tb/tb_irq_dispatch_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch_seq.sv
// irq_dispatch_seq
//   Interrupt dispatch sequencer for the SM83 core. Owns IME and its EI
//   delay, parks the core in HALT, and runs the 5-M-cycle service sequence
//   (two internal waits, push PC high, push PC low, load vector).
//
//   Build option: IRQ_LATE_RESAMPLE_EN
//     defined   - priority index sampled in the PUSH_HI BUS_ACK cycle; an
//                 empty sample yields VEC=0x0000 with no ACK.
//     undefined - priority index latched at W1 entry.
//
// Ports
//   CLK          core clock, one CLK = one M-cycle
//   SYNC_RES     synchronous reset, active-high
//   IRQ_PEND     IE & IF per source, bit 0 highest priority
//   BOUNDARY     current instruction completes this cycle
//   EI/DI/RETI   decoded one-cycle pulses
//   HALT         HALT opcode executed (pulse)
//   PC_IN        return address, valid at dispatch entry
//   BUS_ACK      stack write completed this cycle
//   IME          master interrupt enable
//   BUSY         sequence active or halted
//   HALTED       core parked in HALT
//   WAKE         one-cycle pulse on HALT exit
//   WR_REQ       stack write request, held until BUS_ACK
//   WR_DATA      byte to push
//   SP_DEC       SP decrement pulse before each push
//   PC_LOAD      load PC from VEC
//   VEC          service vector
//   CPU_IRQ_ACK  one-hot clear of the serviced IF bit
module irq_dispatch_seq #(
   parameter logic [15:0] VEC_BASE = 16'h0040
) (
   input  logic        CLK,
   input  logic        SYNC_RES,
   input  logic [7:0]  IRQ_PEND,
   input  logic        BOUNDARY,
   input  logic        EI,
   input  logic        DI,
   input  logic        RETI,
   input  logic        HALT,
   input  logic [15:0] PC_IN,
   input  logic        BUS_ACK,
   output logic        IME,
   output logic        BUSY,
   output logic        HALTED,
   output logic        WAKE,
   output logic        WR_REQ,
   output logic [7:0]  WR_DATA,
   output logic        SP_DEC,
   output logic        PC_LOAD,
   output logic [15:0] VEC,
   output logic [7:0]  CPU_IRQ_ACK
);

   typedef enum logic [2:0] {
      S_IDLE, S_HLT, S_W1, S_W2, S_PUSH_HI, S_PUSH_LO, S_JUMP
   } state_t;

   state_t      state, state_nxt;
   logic        ime, ei_pend, wake_q;
   logic [15:0] ret_pc;
   logic [2:0]  idx_q, pend_idx;
   logic        any_pend, enter_w1, halt_wake, boundary_idle;
`ifdef IRQ_LATE_RESAMPLE_EN
   logic        idx_vld;
`endif

   assign any_pend      = |IRQ_PEND;
   assign boundary_idle = BOUNDARY && (state == S_IDLE);

   // Lowest set bit wins: scan from the top so lower bits overwrite.
   always_comb begin
      pend_idx = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (IRQ_PEND[i-1]) pend_idx = 3'(i - 1);
      end
   end

   always_ff @(posedge CLK) begin
      if (SYNC_RES) begin
         state   <= S_IDLE;
         ime     <= 1'b0;
         ei_pend <= 1'b0;
         wake_q  <= 1'b0;
         ret_pc  <= '0;
         idx_q   <= '0;
`ifdef IRQ_LATE_RESAMPLE_EN
         idx_vld <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         wake_q <= halt_wake;
         if (enter_w1) ret_pc <= PC_IN;
`ifdef IRQ_LATE_RESAMPLE_EN
         if (state == S_PUSH_HI && BUS_ACK) begin
            idx_q   <= pend_idx;
            idx_vld <= any_pend;
         end
`else
         if (enter_w1) idx_q <= pend_idx;
`endif
         // ei_pend is only set after the EI cycle, so the BOUNDARY that
         // promotes it to IME is always a later one; IME itself is
         // registered, so dispatch waits for the boundary after that.
         if (DI) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
         end else begin
            if (EI) ei_pend <= 1'b1;
            else if (ei_pend && boundary_idle) ei_pend <= 1'b0;
            if (RETI || (ei_pend && boundary_idle)) ime <= 1'b1;
         end
         // Dispatch entry overrides any concurrent IME set.
         if (enter_w1) ime <= 1'b0;
      end
   end

   always_comb begin
      state_nxt   = state;
      enter_w1    = 1'b0;
      halt_wake   = 1'b0;
      WR_REQ      = 1'b0;
      WR_DATA     = '0;
      SP_DEC      = 1'b0;
      PC_LOAD     = 1'b0;
      VEC         = '0;
      CPU_IRQ_ACK = '0;
      case (state)
         S_IDLE: begin
            if (BOUNDARY && ime && any_pend) begin
               state_nxt = S_W1;
               enter_w1  = 1'b1;
            end else if (HALT) begin
               if (any_pend) halt_wake = 1'b1;
               else          state_nxt = S_HLT;
            end
         end
         S_HLT: begin
            if (any_pend) begin
               halt_wake = 1'b1;
               if (ime) begin
                  state_nxt = S_W1;
                  enter_w1  = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_W1: state_nxt = S_W2;
         S_W2: begin
            SP_DEC    = 1'b1;
            state_nxt = S_PUSH_HI;
         end
         S_PUSH_HI: begin
            WR_REQ  = 1'b1;
            WR_DATA = ret_pc[15:8];
            if (BUS_ACK) begin
               SP_DEC    = 1'b1;
               state_nxt = S_PUSH_LO;
            end
         end
         S_PUSH_LO: begin
            WR_REQ  = 1'b1;
            WR_DATA = ret_pc[7:0];
            if (BUS_ACK) state_nxt = S_JUMP;
         end
         S_JUMP: begin
            PC_LOAD   = 1'b1;
            state_nxt = S_IDLE;
`ifdef IRQ_LATE_RESAMPLE_EN
            if (idx_vld) begin
               VEC         = VEC_BASE + {10'b0, idx_q, 3'b000};
               CPU_IRQ_ACK = 8'h01 << idx_q;
            end
`else
            VEC         = VEC_BASE + {10'b0, idx_q, 3'b000};
            CPU_IRQ_ACK = 8'h01 << idx_q;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign IME    = ime;
   assign BUSY   = (state != S_IDLE);
   assign HALTED = (state == S_HLT);
   assign WAKE   = wake_q;

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// tb_irq_dispatch_seq
//   Directed bench for irq_dispatch_seq. Inputs change at the falling edge;
//   outputs are checked 1 ns later, well before the next rising edge.
module tb_irq_dispatch_seq;

   logic        CLK = 1'b0;
   logic        SYNC_RES, BOUNDARY, EI, DI, RETI, HALT, BUS_ACK;
   logic [7:0]  IRQ_PEND;
   logic [15:0] PC_IN;
   logic        IME, BUSY, HALTED, WAKE, WR_REQ, SP_DEC, PC_LOAD;
   logic [7:0]  WR_DATA, CPU_IRQ_ACK;
   logic [15:0] VEC;

   int total = 0;
   int bad   = 0;

   irq_dispatch_seq #(.VEC_BASE(16'h0040)) dut (
      .CLK(CLK), .SYNC_RES(SYNC_RES), .IRQ_PEND(IRQ_PEND), .BOUNDARY(BOUNDARY),
      .EI(EI), .DI(DI), .RETI(RETI), .HALT(HALT), .PC_IN(PC_IN),
      .BUS_ACK(BUS_ACK), .IME(IME), .BUSY(BUSY), .HALTED(HALTED), .WAKE(WAKE),
      .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .SP_DEC(SP_DEC), .PC_LOAD(PC_LOAD),
      .VEC(VEC), .CPU_IRQ_ACK(CPU_IRQ_ACK)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and drop all one-cycle pulses.
   task automatic nc();
      @(negedge CLK);
      BOUNDARY = 1'b0;
      EI       = 1'b0;
      DI       = 1'b0;
      RETI     = 1'b0;
      HALT     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      SYNC_RES = 1'b1; BOUNDARY = 1'b0; EI = 1'b0; DI = 1'b0; RETI = 1'b0;
      HALT = 1'b0; BUS_ACK = 1'b1; IRQ_PEND = '0; PC_IN = '0;

      // Reset state
      nc(); nc();
      nc(); SYNC_RES = 1'b0; #1;
      check("rst_ime",     32'(IME), 0);
      check("rst_busy",    32'(BUSY), 0);
      check("rst_halted",  32'(HALTED), 0);
      check("rst_wake",    32'(WAKE), 0);
      check("rst_wrreq",   32'(WR_REQ), 0);
      check("rst_wrdata",  32'(WR_DATA), 0);
      check("rst_spdec",   32'(SP_DEC), 0);
      check("rst_pcload",  32'(PC_LOAD), 0);
      check("rst_vec",     32'(VEC), 0);
      check("rst_ack",     32'(CPU_IRQ_ACK), 0);

      // Basic dispatch, zero-wait bus, priority 0 wins over bit 2
      nc(); RETI = 1'b1; #1;
      nc(); #1; check("a_reti_ime", 32'(IME), 1);
      nc(); BOUNDARY = 1'b1; IRQ_PEND = 8'h05; PC_IN = 16'h1234; #1;
      check("a_t0_busy", 32'(BUSY), 0);
      nc(); PC_IN = 16'hFFFF; #1;
      check("a_t1_busy", 32'(BUSY), 1);
      check("a_t1_ime",  32'(IME), 0);
      check("a_t1_wr",   32'(WR_REQ), 0);
      nc(); #1;
      check("a_t2_spdec", 32'(SP_DEC), 1);
      check("a_t2_wr",    32'(WR_REQ), 0);
      nc(); #1;
      check("a_t3_wr",    32'(WR_REQ), 1);
      check("a_t3_data",  32'(WR_DATA), 'h12);
      check("a_t3_spdec", 32'(SP_DEC), 1);
      nc(); #1;
      check("a_t4_data",  32'(WR_DATA), 'h34);
      check("a_t4_spdec", 32'(SP_DEC), 0);
      check("a_t4_pcld",  32'(PC_LOAD), 0);
      nc(); #1;
      check("a_t5_pcld", 32'(PC_LOAD), 1);
      check("a_t5_vec",  32'(VEC), 'h0040);
      check("a_t5_ack",  32'(CPU_IRQ_ACK), 'h01);
      check("a_t5_ime",  32'(IME), 0);
      nc(); IRQ_PEND = '0; #1;
      check("a_t6_pcld", 32'(PC_LOAD), 0);
      check("a_t6_busy", 32'(BUSY), 0);
      check("a_t6_ack",  32'(CPU_IRQ_ACK), 0);

      // EI delay: boundary at T+1 only arms IME, dispatch at T+3
      nc(); EI = 1'b1; #1;
      nc(); BOUNDARY = 1'b1; IRQ_PEND = 8'h10; #1;
      check("b_t1_ime", 32'(IME), 0);
      nc(); PC_IN = 16'hABCD; #1;
      check("b_t2_busy", 32'(BUSY), 0);
      check("b_t2_ime",  32'(IME), 1);
      nc(); BOUNDARY = 1'b1; #1;
      check("b_t3_busy", 32'(BUSY), 0);
      nc(); #1; check("b_t4_busy", 32'(BUSY), 1);
      nc();
      nc(); #1; check("b_t6_data", 32'(WR_DATA), 'hAB);
      nc(); #1; check("b_t7_data", 32'(WR_DATA), 'hCD);
      nc(); #1;
      check("b_t8_pcld", 32'(PC_LOAD), 1);
      check("b_t8_vec",  32'(VEC), 'h0060);
      check("b_t8_ack",  32'(CPU_IRQ_ACK), 'h10);
      nc(); IRQ_PEND = '0; #1;

      // HALT with IME=0: park, then wake to IDLE with no service
      nc(); HALT = 1'b1; #1;
      check("c_h0_halted", 32'(HALTED), 0);
      nc(); #1;
      check("c_h1_halted", 32'(HALTED), 1);
      check("c_h1_busy",   32'(BUSY), 1);
      check("c_h1_wake",   32'(WAKE), 0);
      nc(); #1; check("c_h2_halted", 32'(HALTED), 1);
      nc(); IRQ_PEND = 8'h04; #1;
      check("c_h3_halted", 32'(HALTED), 1);
      check("c_h3_wake",   32'(WAKE), 0);
      nc(); #1;
      check("c_h4_wake",   32'(WAKE), 1);
      check("c_h4_halted", 32'(HALTED), 0);
      check("c_h4_busy",   32'(BUSY), 0);
      nc(); #1;
      check("c_h5_wake",  32'(WAKE), 0);
      check("c_h5_wr",    32'(WR_REQ), 0);
      check("c_h5_busy",  32'(BUSY), 0);
      check("c_h5_ack",   32'(CPU_IRQ_ACK), 0);
      // HALT with a source already pending is a no-op plus WAKE
      nc(); HALT = 1'b1; #1;
      nc(); #1;
      check("c_nop_wake",   32'(WAKE), 1);
      check("c_nop_halted", 32'(HALTED), 0);
      check("c_nop_busy",   32'(BUSY), 0);
      nc(); IRQ_PEND = '0; #1;
      check("c_nop_wake0", 32'(WAKE), 0);

      // HALT with IME=1: wake straight into service
      nc(); RETI = 1'b1; #1;
      nc(); HALT = 1'b1; #1;
      nc(); #1; check("c2_halted", 32'(HALTED), 1);
      nc(); IRQ_PEND = 8'h08; PC_IN = 16'h2468; #1;
      nc(); #1;
      check("c2_wake",   32'(WAKE), 1);
      check("c2_busy",   32'(BUSY), 1);
      check("c2_halted", 32'(HALTED), 0);
      check("c2_ime",    32'(IME), 0);
      nc();
      nc(); #1; check("c2_data_hi", 32'(WR_DATA), 'h24);
      nc();
      nc(); #1;
      check("c2_pcld", 32'(PC_LOAD), 1);
      check("c2_vec",  32'(VEC), 'h0058);
      check("c2_ack",  32'(CPU_IRQ_ACK), 'h08);
      nc(); IRQ_PEND = '0; #1;

      // Source dropped before the PUSH_HI ack
      nc(); RETI = 1'b1; #1;
      nc(); BOUNDARY = 1'b1; IRQ_PEND = 8'h02; PC_IN = 16'h5678; #1;
      nc(); IRQ_PEND = '0; #1; check("d_t1_busy", 32'(BUSY), 1);
      nc();
      nc(); #1; check("d_t3_data", 32'(WR_DATA), 'h56);
      nc();
      nc(); #1;
      check("d_t5_pcld", 32'(PC_LOAD), 1);
`ifdef IRQ_LATE_RESAMPLE_EN
      check("d_t5_vec", 32'(VEC), 'h0000);
      check("d_t5_ack", 32'(CPU_IRQ_ACK), 'h00);
`else
      check("d_t5_vec", 32'(VEC), 'h0048);
      check("d_t5_ack", 32'(CPU_IRQ_ACK), 'h02);
`endif
      nc(); #1;

      // BUS_ACK delayed three cycles in PUSH_HI
      nc(); RETI = 1'b1; #1;
      nc(); BOUNDARY = 1'b1; IRQ_PEND = 8'h01; PC_IN = 16'h9ABC; BUS_ACK = 1'b0; #1;
      nc();
      nc(); #1; check("e_t2_spdec", 32'(SP_DEC), 1);
      nc(); #1;
      check("e_t3_wr",    32'(WR_REQ), 1);
      check("e_t3_data",  32'(WR_DATA), 'h9A);
      check("e_t3_spdec", 32'(SP_DEC), 0);
      nc(); #1; check("e_t4_data", 32'(WR_DATA), 'h9A);
      nc(); #1;
      check("e_t5_wr",   32'(WR_REQ), 1);
      check("e_t5_data", 32'(WR_DATA), 'h9A);
      nc(); BUS_ACK = 1'b1; #1;
      check("e_t6_data",  32'(WR_DATA), 'h9A);
      check("e_t6_spdec", 32'(SP_DEC), 1);
      nc(); #1;
      check("e_t7_data", 32'(WR_DATA), 'hBC);
      check("e_t7_pcld", 32'(PC_LOAD), 0);
      nc(); #1;
      check("e_t8_pcld", 32'(PC_LOAD), 1);
      check("e_t8_vec",  32'(VEC), 'h0040);
      check("e_t8_ack",  32'(CPU_IRQ_ACK), 'h01);
      nc(); IRQ_PEND = '0; #1;

      // Reset in PUSH_LO aborts; also clears an EI armed just before
      nc(); RETI = 1'b1; #1;
      nc(); BOUNDARY = 1'b1; IRQ_PEND = 8'h01; PC_IN = 16'h1357; #1;
      nc(); nc(); nc();
      nc(); BUS_ACK = 1'b0; EI = 1'b1; #1;
      check("f_t4_wr",   32'(WR_REQ), 1);
      check("f_t4_data", 32'(WR_DATA), 'h57);
      nc(); SYNC_RES = 1'b1; #1;
      check("f_t5_wr", 32'(WR_REQ), 1);
      nc(); SYNC_RES = 1'b0; BUS_ACK = 1'b1; #1;
      check("f_t6_busy",  32'(BUSY), 0);
      check("f_t6_wr",    32'(WR_REQ), 0);
      check("f_t6_data",  32'(WR_DATA), 0);
      check("f_t6_spdec", 32'(SP_DEC), 0);
      check("f_t6_pcld",  32'(PC_LOAD), 0);
      check("f_t6_vec",   32'(VEC), 0);
      check("f_t6_ack",   32'(CPU_IRQ_ACK), 0);
      check("f_t6_ime",   32'(IME), 0);
      nc(); BOUNDARY = 1'b1; #1;
      nc(); #1;
      check("f_t8_busy", 32'(BUSY), 0);
      check("f_t8_ime",  32'(IME), 0);
      nc(); IRQ_PEND = '0; #1;

      // EI and DI together: DI wins, nothing left armed
      nc(); EI = 1'b1; DI = 1'b1; #1;
      nc(); BOUNDARY = 1'b1; #1;
      nc(); #1; check("g_eidi_ime", 32'(IME), 0);
      // DI clears IME immediately
      nc(); RETI = 1'b1; #1;
      nc(); #1; check("g_reti_ime", 32'(IME), 1);
      nc(); DI = 1'b1; #1;
      nc(); #1; check("g_di_ime", 32'(IME), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
